// File: rtl/pll_rst_seq.sv
// PLL reset/lock sequencer: resets the PLL, waits for a settled lock, then releases the system reset.
// Define LOSS_CNT_EN to build the saturating lock-loss counter on loss_cnt (constant 0 otherwise).
//
// state  | meaning
// PRST   | PLL held in reset for RST_CYCLES
// WLOCK  | waiting for synchronized lock, LOCK_TIMEOUT per attempt
// SETTLE | lock must stay high for SETTLE_CYCLES consecutive cycles
// RUN    | clock good, system reset released
// FAIL   | MAX_TRIES attempts failed, PLL held in reset until restart
module pll_rst_seq #(
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT  = 65535,
   parameter int unsigned SETTLE_CYCLES = 1024,
   parameter int unsigned MAX_TRIES     = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       restart,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       clk_ok,
   output logic       fail,
   output logic [2:0] state,
   output logic [7:0] tries,
   output logic [7:0] loss_cnt
);

   localparam int unsigned MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int unsigned MAXC  = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
   localparam int          CW    = $clog2(MAXC + 1);

   localparam logic [CW-1:0] T_RST  = CW'(RST_CYCLES);
   localparam logic [CW-1:0] T_LOCK = CW'(LOCK_TIMEOUT);
   localparam logic [CW-1:0] T_SET  = CW'(SETTLE_CYCLES);
   localparam logic [7:0]    T_TRY  = 8'(MAX_TRIES);

   typedef enum logic [2:0] {
      PRST   = 3'd0,
      WLOCK  = 3'd1,
      SETTLE = 3'd2,
      RUN    = 3'd3,
      FAIL   = 3'd4
   } state_t;

   state_t        cur, nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [7:0]    tries_nxt;
   logic          lk_m, lk_s;
   logic          enter;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lk_m <= 1'b0;
         lk_s <= 1'b0;
      end else begin
         lk_m <= pll_locked;
         lk_s <= lk_m;
      end
   end

   // cnt holds the number of cycles spent in the current state, counting the
   // entry cycle as 1; reset leaves it at 0 so PRST timing starts at the first edge.
   always_comb begin
      nxt       = cur;
      tries_nxt = tries;
      cnt_nxt   = cnt;
      enter     = 1'b0;
      case (cur)
         PRST:   if (cnt == T_RST) nxt = WLOCK;
         WLOCK: begin
            if (lk_s) begin
               nxt = SETTLE;
            end else if (cnt == T_LOCK) begin
               tries_nxt = tries + 8'd1;
               nxt       = (tries_nxt == T_TRY) ? FAIL : PRST;
            end
         end
         SETTLE: begin
            if (!lk_s)              nxt = WLOCK;
            else if (cnt == T_SET)  nxt = RUN;
         end
         RUN: begin
            if (!lk_s) begin
               nxt       = PRST;
               tries_nxt = 8'd0;
            end
         end
         FAIL:   nxt = FAIL;
         default: nxt = PRST;
      endcase
      if (restart) begin
         nxt       = PRST;
         tries_nxt = 8'd0;
      end
      enter = restart || (nxt != cur);
      if (enter)
         cnt_nxt = CW'(1);
      else if (cur == PRST || cur == WLOCK || cur == SETTLE)
         cnt_nxt = cnt + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur       <= PRST;
         cnt       <= '0;
         tries     <= 8'd0;
         pll_rst   <= 1'b1;
         sys_rst_n <= 1'b0;
         clk_ok    <= 1'b0;
         fail      <= 1'b0;
      end else begin
         cur       <= nxt;
         cnt       <= cnt_nxt;
         tries     <= tries_nxt;
         pll_rst   <= (nxt == PRST) || (nxt == FAIL);
         sys_rst_n <= (nxt == RUN);
         clk_ok    <= (nxt == RUN);
         fail      <= (nxt == FAIL);
      end
   end

   assign state = cur;

`ifdef LOSS_CNT_EN
   logic       lost;
   logic [7:0] loss_q;

   // a restart in the same cycle wins, so that loss is not counted
   assign lost = (cur == RUN) && !lk_s && !restart;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         loss_q <= 8'd0;
      else if (lost && loss_q != 8'hff)
         loss_q <= loss_q + 8'd1;
   end

   assign loss_cnt = loss_q;
`else
   assign loss_cnt = 8'd0;
`endif

endmodule
